// File: rtl/exu_ls_agu.sv
`default_nettype none
// ============================================================================
// Module   : exu_ls_agu
// Brief    : Load/store address generation, LSU request issue and load-data
//            alignment/extension. The CIRNO_AGU_MISAL_SPLIT_EN macro enables
//            splitting of bus-word-crossing accesses into two merged parts.
// Revision : 1.0
// ============================================================================
module exu_ls_agu #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hs_ex4ag_val,
    output logic              hs_ag4ex_rdy,
    input  logic              i_ren,
    input  logic              i_wen,
    input  logic [1:0]        i_size,
    input  logic              i_unsg,
    input  logic [XLEN-1:0]   i_base,
    input  logic [XLEN-1:0]   i_imm,
    input  logic [XLEN-1:0]   i_wdat,
    output logic              hs_ag4ls_val,
    input  logic              hs_ls4ag_rdy,
    output logic [XLEN-1:0]   o_ls_adr,
    output logic [XLEN-1:0]   o_ls_wdat,
    output logic [XLEN/8-1:0] o_ls_wen,
    output logic              o_ls_ren,
    input  logic              hs_ls4ag_rval,
    input  logic [XLEN-1:0]   i_ls_rdat,
    output logic              hs_ag4wb_val,
    output logic [XLEN-1:0]   o_res,
    output logic              o_misal
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);

    localparam logic [CW:0] c_depth     = DEPTH;
    localparam logic [CW:0] c_one       = 1;
    localparam logic [1:0]  c_part_full = 2'd0;
    localparam logic [1:0]  c_part_lo   = 2'd1;
    localparam logic [1:0]  c_part_hi   = 2'd2;

    function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [XLEN-1:0] f_extend(input logic [XLEN-1:0] d,
                                                 input logic [1:0]      sz,
                                                 input logic            u);
        logic [XLEN-1:0] m;
        logic            s;
        m = '1;
        s = 1'b0;
        case (sz)
            2'd0:    begin m = XLEN'(8'hFF);         s = d[7];  end
            2'd1:    begin m = XLEN'(16'hFFFF);      s = d[15]; end
            2'd2:    begin m = XLEN'(32'hFFFF_FFFF); s = d[31]; end
            default: begin m = '1;                   s = 1'b0;  end
        endcase
        return (d & m) | ((s & ~u) ? ~m : '0);
    endfunction

    logic [XLEN-1:0] w_ea, w_aln, w_wdat_lo, w_algn;
    logic [OFFW-1:0] w_off;
    logic [3:0]      w_bytes;
    logic [NB-1:0]   w_wen_lo;
    logic [CW:0]     w_need;
    logic            w_acc, w_mem, w_take, w_issue, w_push, w_push2, w_pop, w_idle;

    logic            r_val, r_ren;
    logic [XLEN-1:0] r_adr, r_wdat;
    logic [NB-1:0]   r_wen;

    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [OFFW-1:0] r_f_off  [DEPTH];
    logic [1:0]      r_f_size [DEPTH];
    logic            r_f_unsg [DEPTH];
    logic [1:0]      r_f_part [DEPTH];

    assign w_ea      = i_base + i_imm;
    assign w_off     = w_ea[OFFW-1:0];
    assign w_bytes   = 4'd1 << i_size;
    assign w_aln     = {w_ea[XLEN-1:OFFW], {OFFW{1'b0}}};
    // Mask arithmetic wraps modulo 2^NB, so a full-word access still yields all ones.
    assign w_wen_lo  = ((NB'(1) << w_bytes) - NB'(1)) << w_off;
    assign w_wdat_lo = i_wdat << {w_off, 3'b000};
    assign w_acc     = hs_ex4ag_val & hs_ag4ex_rdy;
    assign w_mem     = i_ren | i_wen;
    assign w_take    = r_val & hs_ls4ag_rdy;
    assign w_pop     = hs_ls4ag_rval & (r_cnt != '0);
    assign w_push    = w_issue & i_ren;

    // No pop-through: only the registered count is used for admission.
    assign hs_ag4ex_rdy = w_idle & (~r_val | hs_ls4ag_rdy) & (({1'b0, r_cnt} + w_need) <= c_depth);

    logic [OFFW-1:0] w_e_off;
    logic [1:0]      w_e_size, w_e_part;
    logic            w_e_unsg;

    assign w_e_off  = r_f_off[r_rptr];
    assign w_e_size = r_f_size[r_rptr];
    assign w_e_unsg = r_f_unsg[r_rptr];
    assign w_e_part = r_f_part[r_rptr];

`ifdef CIRNO_AGU_MISAL_SPLIT_EN
    typedef enum logic [0:0] {IDLE = 1'b0, SPLIT2 = 1'b1} state_t;

    localparam logic [CW:0] c_two = 2;

    state_t          r_state, w_state_nxt;
    logic            r_hi_pend, r_hi_ren, w_ovf, w_load_hi;
    logic [XLEN-1:0] r_hi_adr, r_hi_wdat, r_merge, w_lo_src, w_hi_src;
    logic [NB-1:0]   r_hi_wen, w_wen_hi;
    logic [4:0]      w_end, w_hi_n;
    logic [OFFW:0]   w_nb_off;

    assign w_end     = 5'(w_off) + 5'(w_bytes);
    assign w_ovf     = w_end > 5'(NB);
    assign w_hi_n    = w_end - 5'(NB);
    assign w_wen_hi  = (NB'(1) << w_hi_n) - NB'(1);
    assign w_nb_off  = (OFFW+1)'(NB) - (OFFW+1)'(w_off);
    assign w_issue   = w_acc & w_mem;
    assign w_push2   = w_push & w_ovf;
    assign w_need    = (i_ren & w_ovf) ? c_two : c_one;
    assign w_idle    = (r_state == IDLE);
    assign w_load_hi = (r_state == SPLIT2) & r_hi_pend & w_take;
    assign o_misal   = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // SPLIT2 holds until the HI part itself has been taken by the bus.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_issue && w_ovf) w_state_nxt = SPLIT2;
            SPLIT2:  if (w_take && !r_hi_pend) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_pend <= 1'b0;
            r_hi_adr  <= '0;
            r_hi_wdat <= '0;
            r_hi_wen  <= '0;
            r_hi_ren  <= 1'b0;
        end else if (w_issue && w_ovf) begin
            r_hi_pend <= 1'b1;
            r_hi_adr  <= w_aln + XLEN'(NB);
            r_hi_wdat <= i_wdat >> {w_nb_off, 3'b000};
            r_hi_wen  <= i_wen ? w_wen_hi : '0;
            r_hi_ren  <= i_ren;
        end else if (w_load_hi) begin
            r_hi_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             r_merge <= '0;
        else if (w_pop && w_e_part == c_part_lo) r_merge <= i_ls_rdat;
    end

    assign w_lo_src = (w_e_part == c_part_hi) ? r_merge   : i_ls_rdat;
    assign w_hi_src = (w_e_part == c_part_hi) ? i_ls_rdat : '0;
    assign w_algn   = XLEN'({w_hi_src, w_lo_src} >> {w_e_off, 3'b000});
`else
    logic r_misal, w_misal;

    assign w_misal = |(w_ea[3:0] & (w_bytes - 4'd1));
    assign w_issue = w_acc & w_mem & ~w_misal;
    assign w_push2 = 1'b0;
    assign w_need  = c_one;
    assign w_idle  = 1'b1;
    assign w_algn  = i_ls_rdat >> {w_e_off, 3'b000};
    assign o_misal = r_misal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_misal <= 1'b0;
        else        r_misal <= w_acc & w_mem & w_misal;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val  <= 1'b0;
            r_adr  <= '0;
            r_wdat <= '0;
            r_wen  <= '0;
            r_ren  <= 1'b0;
        end else begin
            if (w_take) r_val <= 1'b0;
            if (w_issue) begin
                r_val  <= 1'b1;
                r_adr  <= w_aln;
                r_wdat <= w_wdat_lo;
                r_wen  <= i_wen ? w_wen_lo : '0;
                r_ren  <= i_ren;
            end
`ifdef CIRNO_AGU_MISAL_SPLIT_EN
            else if (w_load_hi) begin
                r_val  <= 1'b1;
                r_adr  <= r_hi_adr;
                r_wdat <= r_hi_wdat;
                r_wen  <= r_hi_wen;
                r_ren  <= r_hi_ren;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            r_cnt <= r_cnt + CW'({w_push2, w_push & ~w_push2}) - CW'(w_pop);
            if (w_push) r_wptr <= w_push2 ? f_nxt(f_nxt(r_wptr)) : f_nxt(r_wptr);
            if (w_pop)  r_rptr <= f_nxt(r_rptr);
        end
    end

    // Entry storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_f_off[r_wptr]  <= w_off;
            r_f_size[r_wptr] <= i_size;
            r_f_unsg[r_wptr] <= i_unsg;
            r_f_part[r_wptr] <= w_push2 ? c_part_lo : c_part_full;
        end
        if (w_push2) begin
            r_f_off[f_nxt(r_wptr)]  <= w_off;
            r_f_size[f_nxt(r_wptr)] <= i_size;
            r_f_unsg[f_nxt(r_wptr)] <= i_unsg;
            r_f_part[f_nxt(r_wptr)] <= c_part_hi;
        end
    end

    assign hs_ag4ls_val = r_val;
    assign o_ls_adr     = r_adr;
    assign o_ls_wdat    = r_wdat;
    assign o_ls_wen     = r_wen;
    assign o_ls_ren     = r_ren;
    assign hs_ag4wb_val = w_pop & (w_e_part != c_part_lo);
    assign o_res        = hs_ag4wb_val ? f_extend(w_algn, w_e_size, w_e_unsg) : '0;

endmodule
`default_nettype wire

// File: tb/tb_exu_ls_agu.sv
`default_nettype none
// ============================================================================
// Module   : tb_exu_ls_agu
// Brief    : Directed vector table plus hand-written multi-cycle sequences for
//            exu_ls_agu (XLEN=32, DEPTH=2).
// Revision : 1.0
// ============================================================================
module tb_exu_ls_agu;
    localparam int XLEN = 32;
    localparam int NB   = 4;
    localparam int NV   = 9;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            hs_ex4ag_val, hs_ag4ex_rdy;
    logic            i_ren, i_wen, i_unsg;
    logic [1:0]      i_size;
    logic [XLEN-1:0] i_base, i_imm, i_wdat;
    logic            hs_ag4ls_val, hs_ls4ag_rdy;
    logic [XLEN-1:0] o_ls_adr, o_ls_wdat;
    logic [NB-1:0]   o_ls_wen;
    logic            o_ls_ren;
    logic            hs_ls4ag_rval;
    logic [XLEN-1:0] i_ls_rdat;
    logic            hs_ag4wb_val;
    logic [XLEN-1:0] o_res;
    logic            o_misal;

    int n_pass = 0;
    int n_tot  = 0;

    exu_ls_agu #(.XLEN(XLEN), .DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hs_ex4ag_val (hs_ex4ag_val),
        .hs_ag4ex_rdy (hs_ag4ex_rdy),
        .i_ren        (i_ren),
        .i_wen        (i_wen),
        .i_size       (i_size),
        .i_unsg       (i_unsg),
        .i_base       (i_base),
        .i_imm        (i_imm),
        .i_wdat       (i_wdat),
        .hs_ag4ls_val (hs_ag4ls_val),
        .hs_ls4ag_rdy (hs_ls4ag_rdy),
        .o_ls_adr     (o_ls_adr),
        .o_ls_wdat    (o_ls_wdat),
        .o_ls_wen     (o_ls_wen),
        .o_ls_ren     (o_ls_ren),
        .hs_ls4ag_rval(hs_ls4ag_rval),
        .i_ls_rdat    (i_ls_rdat),
        .hs_ag4wb_val (hs_ag4wb_val),
        .o_res        (o_res),
        .o_misal      (o_misal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            ren;
        logic            wen;
        logic [1:0]      size;
        logic            unsg;
        logic [XLEN-1:0] base;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] wdat;
        logic [XLEN-1:0] rdat;
        logic [XLEN-1:0] x_adr;
        logic [NB-1:0]   x_wen;
        logic [XLEN-1:0] x_wdat;
        logic [XLEN-1:0] x_res;
    } vec_t;

    vec_t vecs[NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic drive(input logic ren, input logic wen, input logic [1:0] size,
                         input logic unsg, input logic [XLEN-1:0] base,
                         input logic [XLEN-1:0] imm, input logic [XLEN-1:0] wdat);
        hs_ex4ag_val = 1'b1;
        i_ren  = ren;
        i_wen  = wen;
        i_size = size;
        i_unsg = unsg;
        i_base = base;
        i_imm  = imm;
        i_wdat = wdat;
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_lsval"}, 64'(hs_ag4ls_val), 64'h0);
        chk({nm, "_adr"},   64'(o_ls_adr),     64'h0);
        chk({nm, "_wdat"},  64'(o_ls_wdat),    64'h0);
        chk({nm, "_wen"},   64'(o_ls_wen),     64'h0);
        chk({nm, "_ren"},   64'(o_ls_ren),     64'h0);
        chk({nm, "_misal"}, 64'(o_misal),      64'h0);
        chk({nm, "_wbval"}, 64'(hs_ag4wb_val), 64'h0);
        chk({nm, "_res"},   64'(o_res),        64'h0);
        chk({nm, "_rdy"},   64'(hs_ag4ex_rdy), 64'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; hs_ex4ag_val = 1'b0; i_ren = 1'b0; i_wen = 1'b0; i_size = 2'd0;
        i_unsg = 1'b0; i_base = '0; i_imm = '0; i_wdat = '0; hs_ls4ag_rdy = 1'b1;
        hs_ls4ag_rval = 1'b0; i_ls_rdat = '0;

        //            ren   wen   sz    unsg  base          imm           wdat          rdat          adr           wen   wdat          res
        vecs[0] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0100, 32'h0000_0003, 32'h0,        32'h80FF_FFFF, 32'h0000_0100, 4'h0, 32'h0,        32'hFFFF_FF80};
        vecs[1] = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0100, 32'h0000_0003, 32'h0,        32'h80FF_FFFF, 32'h0000_0100, 4'h0, 32'h0,        32'h0000_0080};
        vecs[2] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0200, 32'h0000_0002, 32'h1234_ABCD, 32'h0,        32'h0000_0200, 4'hC, 32'hABCD_0000, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 32'h0000_0310, 4'h0, 32'h0,        32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0400, 32'hFFFF_FFFE, 32'h0,        32'h8001_1234, 32'h0000_03FC, 4'h0, 32'h0,        32'hFFFF_8001};
        vecs[5] = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0400, 32'hFFFF_FFFE, 32'h0,        32'h8001_1234, 32'h0000_03FC, 4'h0, 32'h0,        32'h0000_8001};
        vecs[6] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0500, 32'h0000_0001, 32'h0000_00A5, 32'h0,        32'h0000_0500, 4'h2, 32'h0000_A500, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0600, 32'h0000_0004, 32'hCAFE_F00D, 32'h0,        32'h0000_0604, 4'hF, 32'hCAFE_F00D, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0700, 32'h0000_0001, 32'h0,        32'h1234_5678, 32'h0000_0700, 4'h0, 32'h0,        32'h0000_0056};

        // Reset state
        @(negedge clk);
        chk_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: one request, one bus take, one response for loads
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].ren, vecs[i].wen, vecs[i].size, vecs[i].unsg,
                  vecs[i].base, vecs[i].imm, vecs[i].wdat);
            #1 chk($sformatf("v%0d_rdy", i), 64'(hs_ag4ex_rdy), 64'h1);
            @(negedge clk);
            hs_ex4ag_val = 1'b0;
            chk($sformatf("v%0d_lsval", i), 64'(hs_ag4ls_val), 64'h1);
            chk($sformatf("v%0d_adr", i),   64'(o_ls_adr),     64'(vecs[i].x_adr));
            chk($sformatf("v%0d_wen", i),   64'(o_ls_wen),     64'(vecs[i].x_wen));
            chk($sformatf("v%0d_wdat", i),  64'(o_ls_wdat),    64'(vecs[i].x_wdat));
            chk($sformatf("v%0d_ren", i),   64'(o_ls_ren),     64'(vecs[i].ren));
            if (vecs[i].ren) begin
                hs_ls4ag_rval = 1'b1;
                i_ls_rdat     = vecs[i].rdat;
                #1;
                chk($sformatf("v%0d_wbval", i), 64'(hs_ag4wb_val), 64'h1);
                chk($sformatf("v%0d_res", i),   64'(o_res),        64'(vecs[i].x_res));
            end
            @(negedge clk);
            hs_ls4ag_rval = 1'b0;
            #1;
            chk($sformatf("v%0d_lsval_done", i), 64'(hs_ag4ls_val), 64'h0);
            chk($sformatf("v%0d_wbval_done", i), 64'(hs_ag4wb_val), 64'h0);
        end

        // FIFO full: third lw stalls until the first response has popped
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h800, 32'h0, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h804, 32'h0, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h808, 32'h0, 32'h0);
        #1 chk("full_rdy0", 64'(hs_ag4ex_rdy), 64'h0);
        @(negedge clk);
        #1 chk("full_rdy1", 64'(hs_ag4ex_rdy), 64'h0);
        @(negedge clk);
        hs_ls4ag_rval = 1'b1;
        i_ls_rdat     = 32'h1111_1111;
        #1;
        chk("full_wbval1", 64'(hs_ag4wb_val), 64'h1);
        chk("full_res1",   64'(o_res),        64'h1111_1111);
        chk("full_nopass", 64'(hs_ag4ex_rdy), 64'h0);
        @(negedge clk);
        hs_ls4ag_rval = 1'b0;
        #1 chk("full_rdy_back", 64'(hs_ag4ex_rdy), 64'h1);
        @(negedge clk);
        hs_ex4ag_val = 1'b0;
        chk("full_lsval3", 64'(hs_ag4ls_val), 64'h1);
        chk("full_adr3",   64'(o_ls_adr),     64'h808);
        hs_ls4ag_rval = 1'b1;
        i_ls_rdat     = 32'h2222_2222;
        #1 chk("full_res2", 64'(o_res), 64'h2222_2222);
        @(negedge clk);
        i_ls_rdat = 32'h3333_3333;
        #1 chk("full_res3", 64'(o_res), 64'h3333_3333);
        @(negedge clk);
        hs_ls4ag_rval = 1'b0;
        #1 chk("full_empty_wb", 64'(hs_ag4wb_val), 64'h0);

        // Bus backpressure: pending sw held stable for three cycles
        hs_ls4ag_rdy = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h900, 32'h0, 32'h55AA_33CC);
        @(negedge clk);
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'hA00, 32'h0, 32'h0BAD_0BAD);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_lsval", c), 64'(hs_ag4ls_val), 64'h1);
            chk($sformatf("bp%0d_adr", c),   64'(o_ls_adr),     64'h900);
            chk($sformatf("bp%0d_wdat", c),  64'(o_ls_wdat),    64'h55AA_33CC);
            chk($sformatf("bp%0d_wen", c),   64'(o_ls_wen),     64'hF);
            chk($sformatf("bp%0d_rdy", c),   64'(hs_ag4ex_rdy), 64'h0);
            @(negedge clk);
        end
        hs_ex4ag_val = 1'b0;
        hs_ls4ag_rdy = 1'b1;
        @(negedge clk);
        #1 chk("bp_done", 64'(hs_ag4ls_val), 64'h0);

`ifdef CIRNO_AGU_MISAL_SPLIT_EN
        // Split store across the word boundary
        @(negedge clk);
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'h2, 32'h1122_3344);
        @(negedge clk);
        hs_ex4ag_val = 1'b0;
        chk("ss_lo_adr",  64'(o_ls_adr),  64'h100);
        chk("ss_lo_wen",  64'(o_ls_wen),  64'hC);
        chk("ss_lo_wdat", 64'(o_ls_wdat), 64'h3344_0000);
        chk("ss_rdy",     64'(hs_ag4ex_rdy), 64'h0);
        @(negedge clk);
        chk("ss_hi_adr",  64'(o_ls_adr),  64'h104);
        chk("ss_hi_wen",  64'(o_ls_wen),  64'h3);
        chk("ss_hi_wdat", 64'(o_ls_wdat), 64'h0000_1122);
        @(negedge clk);
        chk("ss_done", 64'(hs_ag4ls_val), 64'h0);

        // Split load, merged on the HI response
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h2, 32'h0);
        @(negedge clk);
        hs_ex4ag_val = 1'b0;
        chk("sl_lo_adr", 64'(o_ls_adr), 64'h100);
        chk("sl_lo_ren", 64'(o_ls_ren), 64'h1);
        chk("sl_misal",  64'(o_misal),  64'h0);
        @(negedge clk);
        chk("sl_hi_adr", 64'(o_ls_adr), 64'h104);
        hs_ls4ag_rval = 1'b1;
        i_ls_rdat     = 32'hBBBB_1234;
        #1 chk("sl_lo_nowb", 64'(hs_ag4wb_val), 64'h0);
        @(negedge clk);
        i_ls_rdat = 32'h5678_AAAA;
        #1;
        chk("sl_wbval", 64'(hs_ag4wb_val), 64'h1);
        chk("sl_res",   64'(o_res),        64'hAAAA_BBBB);
        chk("sl_rdy",   64'(hs_ag4ex_rdy), 64'h1);
        @(negedge clk);
        hs_ls4ag_rval = 1'b0;

        // Reset while SPLIT2 is pending; stale response must be dropped
        hs_ls4ag_rdy = 1'b0;
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h2, 32'h0);
        @(negedge clk);
        hs_ex4ag_val = 1'b0;
        chk("rs_pending", 64'(hs_ag4ls_val), 64'h1);
        chk("rs_busy",    64'(hs_ag4ex_rdy), 64'h0);
`else
        // Misaligned lw: exception pulse, no bus traffic, no FIFO entry
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h2, 32'h0);
        @(negedge clk);
        hs_ex4ag_val = 1'b0;
        chk("mis_pulse", 64'(o_misal),      64'h1);
        chk("mis_nobus", 64'(hs_ag4ls_val), 64'h0);
        @(negedge clk);
        chk("mis_drop",  64'(o_misal),      64'h0);
        chk("mis_nobus2", 64'(hs_ag4ls_val), 64'h0);
        hs_ls4ag_rval = 1'b1;
        i_ls_rdat     = 32'hFFFF_FFFF;
        #1 chk("mis_nowb", 64'(hs_ag4wb_val), 64'h0);
        @(negedge clk);
        hs_ls4ag_rval = 1'b0;

        // Reset with a load pending on a stalled bus
        hs_ls4ag_rdy = 1'b0;
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'hB00, 32'h0, 32'h0);
        @(negedge clk);
        hs_ex4ag_val = 1'b0;
        chk("rs_pending", 64'(hs_ag4ls_val), 64'h1);
`endif
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("rs");
        #1 rst_n = 1'b1;
        hs_ls4ag_rdy = 1'b1;
        @(negedge clk);
        hs_ls4ag_rval = 1'b1;
        i_ls_rdat     = 32'h1234_5678;
        #1;
        chk("rs_stale_wb",  64'(hs_ag4wb_val), 64'h0);
        chk("rs_stale_res", 64'(o_res),        64'h0);
        @(negedge clk);
        hs_ls4ag_rval = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
`default_nettype wire
